wb_trace_uart_tx: RTL
=====================

// Module: wb_trace_uart_tx
// PURPOSE
//  On-board counterpart of the simulation trace dump. Sits beside Processor on the FPGA top and
//  captures every writeback value (out_write_data) into a FIFO. Streams the values out over a
//  UART TX line so a host can rebuild the same trace the bench writes to file.
//  Each captured word goes out as 4 bytes, big-endian, 8N1.
// PARAMETERS
//  DATA_W        32   width of captured writeback word (multiple of 8)
//  FIFO_DEPTH    16   capture FIFO entries; power of 2, >= 2
//  CLKS_PER_BIT  868  Clk cycles per UART bit (100 MHz / 115200); >= 2
//  SKIP_ZERO     1    1: words equal to 0 are not captured; 0: capture all valid words
// PORTS
//  Clk            in   1                        system clock, rising edge
//  Reset          in   1                        asynchronous, active-low reset
//  in_valid       in   1                        writeback occurring this cycle
//  in_write_data  in   DATA_W                   writeback value (Processor out_write_data)
//  uart_tx        out  1                        serial line, idle high
//  fifo_count     out  $clog2(FIFO_DEPTH)+1     words currently queued (not incl. word in flight)
//  busy           out  1                        1 while a word is being serialized
//  overflow       out  1                        sticky: a capture was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (Reset==0, async): uart_tx=1, fifo_count=0, busy=0, overflow=0, FSM=IDLE, FIFO emptied.
//   - Mid-frame reset aborts the frame: line returns high at once; the partial word is lost.
//  Capture: on an edge with in_valid=1 and (SKIP_ZERO==0 or in_write_data!=0), push in_write_data.
//   - Push accepted if FIFO not full, or if full and a pop happens on the same edge.
//   - Otherwise the word is dropped and overflow is set to 1; overflow clears only on reset.
//   - Simultaneous push+pop leaves fifo_count unchanged.
//  FIFO: read/write pointers wrap modulo FIFO_DEPTH; count is the separate 0..FIFO_DEPTH register.
//  TX FSM states: IDLE, START, DATA, STOP.
//   - IDLE: if fifo_count!=0, pop into a DATA_W shift reg, set byte_idx=0, go START, busy=1.
//   - START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA with bit_idx=0.
//   - DATA: uart_tx = current byte bit[bit_idx], LSB first, CLKS_PER_BIT cycles each.
//     After bit 7 -> STOP.
//   - STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then if byte_idx<DATA_W/8-1: byte_idx++ -> START.
//     Else if FIFO non-empty: pop next word -> START (back-to-back, no idle gap).
//     Else -> IDLE with busy=0.
//   - Byte order: byte_idx 0 sends bits [DATA_W-1:DATA_W-8] (big-endian).
//  Outputs are registered; uart_tx is glitch-free (driven from a flop).
//  Latency: word captured at edge N into empty FIFO with FSM IDLE.
//   - Pop at edge N+1; uart_tx falls at edge N+1; fifo_count returns to 0 at edge N+1.
//  Word time = (DATA_W/8)*10*CLKS_PER_BIT cycles; baud counter counts 0..CLKS_PER_BIT-1,
//  then reloads.
//  in_valid with in_write_data=0 and SKIP_ZERO=1: no push, no count change, no overflow.
// STRUCTURE
//  Shared package wb_trace_pkg: TX state encoding (IDLE/START/DATA/STOP),
//  UART_BITS_PER_BYTE=8, default CLKS_PER_BIT constant.
//  Sub-module trace_sync_fifo (DATA_W, FIFO_DEPTH): push/pop/full/empty/count, single clock,
//  same async active-low reset. FSM, baud counter and shifter stay in wb_trace_uart_tx.
// TESTING  (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4, SKIP_ZERO=1 unless noted)
//  1 Reset: hold Reset=0 3 cycles -> uart_tx=1, fifo_count=0, busy=0, overflow=0.
//  2 Single word 32'h12345678 at edge N -> uart_tx low from N+1 for 4 cycles.
//    Decoded bytes: 0x12,0x34,0x56,0x78. busy falls after 160 cycles.
//  3 Zero filter: in_valid with data 0 -> fifo_count stays 0, line stays 1.
//    Repeat with SKIP_ZERO=0 -> 4 bytes 0x00 sent.
//  4 Overflow: push 6 non-zero words on consecutive edges (1 popped, 4 queued, 1 dropped).
//    Result: overflow=1, host receives exactly 5 words in order, no gap between frames.
//  5 Full+pop same edge: FIFO full, push on the pop edge -> accepted, overflow stays 0,
//    count stays 4.
//  6 Reset mid-byte 2 of a word -> uart_tx=1 immediately, fifo_count=0.
//    A new word after release transmits cleanly from byte 0.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared definitions for the writeback trace UART streamer: TX state encoding and UART constants.
package wb_trace_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;
  localparam int UART_BITS_PER_BYTE   = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
endpackage

// File: rtl/trace_sync_fifo.sv
// Single-clock capture FIFO for trace words. A push into a full FIFO is taken only when a pop
// happens on the same edge; the caller sees drops through full/pop.
module trace_sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/wb_trace_uart_tx.sv
// Captures writeback values into a FIFO and streams each word out as big-endian 8N1 bytes.
module wb_trace_uart_tx
  import wb_trace_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SKIP_ZERO    = 1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_write_data,
  output logic                        uart_tx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        overflow
);
  localparam int NB  = DATA_W / UART_BITS_PER_BYTE;
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CTW = $clog2(CLKS_PER_BIT);
  localparam logic [CTW-1:0] BAUD_LAST = CTW'(CLKS_PER_BIT - 1);
  localparam logic [BIW-1:0] BYTE_LAST = BIW'(NB - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(UART_BITS_PER_BYTE - 1);

  tx_state_e         state_q, state_d;
  logic [CTW-1:0]    baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [BIW-1:0]    byte_q, byte_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d;

  logic              push, pop, f_full, f_empty, baud_end;
  logic [DATA_W-1:0] f_rdata;
  logic [UART_BITS_PER_BYTE-1:0] cur_byte;

  assign push     = in_valid && ((SKIP_ZERO == 0) || (in_write_data != '0));
  assign baud_end = (baud_q == BAUD_LAST);
  assign cur_byte = sh_q[DATA_W-1 -: UART_BITS_PER_BYTE];

  trace_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .wdata (in_write_data),
    .pop   (pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    // A full-FIFO push survives only if the FSM pops on the same edge.
    ovf_d   = ovf_q | (push & f_full & ~pop);
    case (state_q)
      ST_IDLE: begin
        if (!f_empty) begin
          pop     = 1'b1;
          sh_d    = f_rdata;
          byte_d  = '0;
          baud_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = cur_byte[0];
          state_d = ST_DATA;
        end else baud_d = baud_q + 1'b1;
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else baud_d = baud_q + 1'b1;
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q != BYTE_LAST) begin
            byte_d  = byte_q + 1'b1;
            sh_d    = sh_q << UART_BITS_PER_BYTE;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else if (!f_empty) begin
            // Chain the next word straight into its start bit.
            pop     = 1'b1;
            sh_d    = f_rdata;
            byte_d  = '0;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else baud_d = baud_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    ovf_d = ovf_q | (push & f_full & ~pop);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
endmodule
